// File: rtl/mo_mul_array_if.sv
// Operand/result bundle interface for the lane-parallel Montgomery multiplier.
// Valid/ready: a bundle moves on a rising edge where valid & ready are both 1;
// once valid is raised, the source holds the payload stable until that transfer.
interface mo_mul_array_if #(
  parameter int DATA_WIDTH = 12,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 4
);
  logic                              in_valid;
  logic                              in_ready;
  logic                              in_lazy;
  logic [TAG_WIDTH-1:0]              in_tag;
  logic [LANES*DATA_WIDTH-1:0]       in_a;
  logic [LANES*DATA_WIDTH-1:0]       in_b;
  logic                              out_valid;
  logic                              out_ready;
  logic [TAG_WIDTH-1:0]              out_tag;
  logic [LANES*(DATA_WIDTH+1)-1:0]   out_res;
  logic                              busy;

  modport master (
    output in_valid, in_lazy, in_tag, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_tag, out_res, busy
  );

  modport slave (
    input  in_valid, in_lazy, in_tag, in_a, in_b, out_ready,
    output in_ready, out_valid, out_tag, out_res, busy
  );
endinterface

// File: rtl/mo_mul_array.sv
// Multi-lane pipelined Montgomery multiplier: res = a*b*2^-DATA_WIDTH mod Q per lane,
// fully reduced or lazy in [0,2Q), with a global stall driven by output back-pressure.
module mo_mul_array #(
  parameter int DATA_WIDTH    = 12,
  parameter int Q             = 3329,
  parameter int QINV          = 3327,
  parameter int LANES         = 4,
  parameter int MUL_STAGE_CNT = 3,
  parameter int TAG_WIDTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  mo_mul_array_if.slave   bus
);
  localparam int DW = DATA_WIDTH;
  localparam int NS = MUL_STAGE_CNT;
  localparam int NR = MUL_STAGE_CNT - 2;
  localparam logic [DW-1:0] Q_C    = DW'(Q);
  localparam logic [DW-1:0] QINV_C = DW'(QINV);

  if (MUL_STAGE_CNT < 3) begin : g_chk_stages
    $error("mo_mul_array: MUL_STAGE_CNT must be at least 3");
  end
  if (((Q * QINV) + 1) % (1 << DATA_WIDTH) != 0) begin : g_chk_qinv
    $error("mo_mul_array: QINV is not -Q^-1 mod 2^DATA_WIDTH");
  end
  if (2 * Q >= (1 << (DATA_WIDTH + 1))) begin : g_chk_q
    $error("mo_mul_array: 2*Q does not fit in DATA_WIDTH+1 bits");
  end

  // Stage 0 holds t, stage 1 holds t and m, stages 2.. hold the result.
  logic [NS-1:0]                       vld_q, vld_d;
  logic [NS-1:0]                       lazy_q, lazy_d;
  logic [NS-1:0][TAG_WIDTH-1:0]        tag_q, tag_d;
  logic [LANES-1:0][2*DW-1:0]          t1_q, t1_d;
  logic [LANES-1:0][2*DW-1:0]          t2_q, t2_d;
  logic [LANES-1:0][DW-1:0]            m2_q, m2_d;
  logic [NR-1:0][LANES-1:0][DW:0]      res_q, res_d;

  logic [LANES-1:0][2*DW-1:0]          ab_prod;
  logic [LANES-1:0][DW-1:0]            m_lo;
  logic [LANES-1:0][DW:0]              red;
  logic                                stall;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] a_l;
    logic [DW-1:0] b_l;
    logic [2*DW:0] redc_sum;
    logic [DW:0]   u;

    assign a_l        = bus.in_a[l*DW +: DW];
    assign b_l        = bus.in_b[l*DW +: DW];
    assign ab_prod[l] = {{DW{1'b0}}, a_l} * {{DW{1'b0}}, b_l};
    assign m_lo[l]    = DW'(t1_q[l][DW-1:0] * QINV_C);
    // Low DW bits of the sum are zero by construction of m.
    assign redc_sum   = {1'b0, t2_q[l]} + ({{(DW+1){1'b0}}, m2_q[l]} * {{(DW+1){1'b0}}, Q_C});
    assign u          = (DW+1)'(redc_sum >> DW);
    assign red[l]     = (lazy_q[1] || (u < {1'b0, Q_C})) ? u : u - {1'b0, Q_C};
  end

  always_comb begin
    stall  = vld_q[NS-1] & ~bus.out_ready;
    vld_d  = vld_q;
    lazy_d = lazy_q;
    tag_d  = tag_q;
    t1_d   = t1_q;
    t2_d   = t2_q;
    m2_d   = m2_q;
    res_d  = res_q;
    if (!stall) begin
      vld_d    = {vld_q[NS-2:0], bus.in_valid};
      lazy_d   = {lazy_q[NS-2:0], bus.in_lazy};
      tag_d    = {tag_q[NS-2:0], bus.in_tag};
      t1_d     = ab_prod;
      t2_d     = t1_q;
      m2_d     = m_lo;
      res_d[0] = red;
      for (int s = 1; s < NR; s++) begin
        res_d[s] = res_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      lazy_q <= '0;
      tag_q  <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
      m2_q   <= '0;
      res_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      lazy_q <= lazy_d;
      tag_q  <= tag_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      m2_q   <= m2_d;
      res_q  <= res_d;
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_q[NS-1];
  assign bus.out_tag   = tag_q[NS-1];
  assign bus.out_res   = res_q[NR-1];
  assign bus.busy      = |vld_q;
endmodule

// File: tb/tb_mo_mul_array.sv
// Bench for mo_mul_array: directed Montgomery vectors, sweep, back-pressure,
// mid-flight reset and sparse traffic, checked against a modular-inverse model.
module tb_mo_mul_array;
  localparam int DW    = 12;
  localparam int Q     = 3329;
  localparam int LANES = 4;
  localparam int TW    = 4;
  localparam int NS    = 3;
  localparam int RINV  = 2704;
  localparam int EW    = LANES + 1 + TW + LANES*DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mo_mul_array_if #(.DATA_WIDTH(DW), .LANES(LANES), .TAG_WIDTH(TW)) bus();

  mo_mul_array #(
    .DATA_WIDTH(DW), .Q(Q), .QINV(3327), .LANES(LANES),
    .MUL_STAGE_CNT(NS), .TAG_WIDTH(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int               n_checks  = 0;
  int               n_errors  = 0;
  int               n_out     = 0;
  int               hold_left = 0;
  logic [LANES-1:0] care_mask = '1;
  logic [EW-1:0]    exp_q[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic int mont_ref(input int a, input int b);
    return (((a * b) % Q) * RINV) % Q;
  endfunction

  function automatic logic [LANES*DW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  // Input side: every accepted bundle becomes one expected entry.
  logic [EW-1:0] in_e;
  always @(negedge clk) begin
    if (rst && bus.in_valid && bus.in_ready) begin
      in_e = '0;
      in_e[EW-1 -: LANES]     = care_mask;
      in_e[LANES*DW+TW]       = bus.in_lazy;
      in_e[LANES*DW +: TW]    = bus.in_tag;
      for (int l = 0; l < LANES; l++) begin
        in_e[l*DW +: DW] = DW'(mont_ref(int'(bus.in_a[l*DW +: DW]), int'(bus.in_b[l*DW +: DW])));
      end
      exp_q.push_back(in_e);
    end
  end

  // Output side: scoreboard compare plus hold-stability under back-pressure.
  logic [EW-1:0]               mon_e;
  logic [DW:0]                 mon_got;
  logic                        held = 1'b0;
  logic [TW-1:0]               held_tag;
  logic [LANES*(DW+1)-1:0]     held_res;
  always @(negedge clk) begin
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_tag", bus.out_tag, held_tag);
        check("hold_res", bus.out_res, held_res);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          n_out++;
          check("out_tag", bus.out_tag, mon_e[LANES*DW +: TW]);
          for (int l = 0; l < LANES; l++) begin
            if (mon_e[EW-LANES+l]) begin
              mon_got = bus.out_res[l*(DW+1) +: DW+1];
              if (mon_e[LANES*DW+TW]) begin
                check($sformatf("lazy_range_l%0d", l), mon_got < (DW+1)'(2*Q), 1);
                check($sformatf("lazy_cong_l%0d", l), mon_got % Q, mon_e[l*DW +: DW]);
              end else begin
                check($sformatf("res_l%0d", l), mon_got, mon_e[l*DW +: DW]);
              end
            end
          end
        end
      end
      held     = bus.out_valid && !bus.out_ready;
      held_tag = bus.out_tag;
      held_res = bus.out_res;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hold_left > 0) begin
      bus.out_ready = 1'b0;
      hold_left--;
    end else begin
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic send(input logic [TW-1:0] tag, input logic lazy,
                      input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                      output int waits);
    tick();
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_lazy  = lazy;
    bus.in_a     = a;
    bus.in_b     = b;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      tick();
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_single(input logic [TW-1:0] tag, input logic [LANES*DW-1:0] a,
                            input logic [LANES*DW-1:0] b, input int ex [LANES]);
    int w;
    send(tag, 1'b0, a, b, w);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", bus.out_valid, 0);
    check("lat_c1_busy", bus.busy, 1);
    tick();
    @(negedge clk);
    check("lat_c2_valid", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_c3_valid", bus.out_valid, 1);
    check("single_tag", bus.out_tag, tag);
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("single_res_l%0d", l), bus.out_res[l*(DW+1) +: DW+1], ex[l]);
    end
    tick();
    @(negedge clk);
    check("single_busy_drop", bus.busy, 0);
  endtask

  initial begin
    int w;
    int n_before;
    logic busy_exp;
    bus.in_valid  = 1'b0;
    bus.in_lazy   = 1'b0;
    bus.in_tag    = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_res", bus.out_res, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed: R mod Q times b returns b; edge pairs per lane
    run_single(4'd1, pack4(767, 767, 767, 767), pack4(1234, 1234, 1234, 1234),
               '{1234, 1234, 1234, 1234});
    run_single(4'd2, pack4(1, 3328, 0, 767), pack4(1, 3328, 3328, 1234),
               '{2704, 2704, 0, 1234});

    // Out-of-contract operands on lane 3 must leave lanes 0..2 intact
    care_mask = 4'b0111;
    send(4'd3, 1'b0, pack4(5, 6, 3328, 4095), pack4(9, 10, 2, 4095), w);
    idle(5);
    care_mask = '1;

    // Back-pressure mid-stream
    n_before = n_out;
    for (int t = 0; t < 16; t++) begin
      if (t == 8) hold_left = 5;
      send(TW'(t), 1'b0, pack4(t, t + 100, 3000 - t, 767), pack4(t + 7, 2 * t, 55, t + 1), w);
      if (t == 8) check("bp_waits", w, 5);
    end
    idle(6);
    check("bp_count", n_out - n_before, 16);
    check("bp_drain", exp_q.size(), 0);

    // Sweep on lane 0, random other lanes, random lazy and back-pressure
    for (int i = 0; i < 300; i++) begin
      int a0;
      int b0;
      a0 = (i == 0) ? 0 : (i == 1) ? Q - 1 : (i * 191 + 7) % Q;
      b0 = (i == 1) ? Q - 1 : (i * 577 + 3) % Q;
      if ($urandom_range(0, 9) == 0) hold_left = $urandom_range(1, 3);
      send(TW'(i), 1'($urandom_range(0, 1)),
           pack4(a0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1)),
           pack4(b0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1)), w);
    end
    idle(8);
    check("sweep_drain", exp_q.size(), 0);

    // Sparse traffic: one bundle every third cycle
    for (int j = 0; j < 15; j++) begin
      tick();
      bus.in_valid = (j % 3 == 0) && (j < 12);
      bus.in_tag   = TW'(j);
      bus.in_lazy  = 1'b0;
      bus.in_a     = pack4(j + 1, j + 2, j + 3, j + 4);
      bus.in_b     = pack4(2 * j, 3 * j, 11, 3328);
      @(negedge clk);
      busy_exp = 1'b0;
      for (int k = j - 3; k < j; k++) begin
        if (k >= 0 && k < 12 && k % 3 == 0) busy_exp = 1'b1;
      end
      check("sparse_valid", bus.out_valid, (j >= 3) && ((j - 3) % 3 == 0) && (j - 3 < 12));
      check("sparse_busy", bus.busy, busy_exp);
    end
    check("sparse_drain", exp_q.size(), 0);

    // Reset with three bundles in flight
    send(4'd10, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), w);
    send(4'd11, 1'b0, pack4(9, 10, 11, 12), pack4(5, 6, 7, 8), w);
    send(4'd12, 1'b1, pack4(13, 14, 15, 16), pack4(5, 6, 7, 8), w);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_busy", bus.busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      check("no_stale_valid", bus.out_valid, 0);
    end
    run_single(4'd13, pack4(3328, 1, 767, 0), pack4(3328, 1, 1, 0), '{2704, 2704, 1, 0});

    idle(5);
    check("final_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end
endmodule
